// File: rtl/io_poll_ctrl.sv
// Bridge-port sequencer: shares the single bridge port between CPU accesses and a
// periodic poll engine that copies the switch device into the LED device.
module io_poll_ctrl #(
  parameter int unsigned POLL_DIV = 50000,
  parameter logic [31:0] SW_ADDR  = 32'h0000_7F2C,
  parameter logic [31:0] LED_ADDR = 32'h0000_7F34,
  localparam int unsigned DW  = 32,
  localparam int unsigned BEW = 4,
  localparam int unsigned CW  = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           poll_en,
  input  logic           cpu_req,
  input  logic [DW-1:0]  cpu_addr,
  input  logic [DW-1:0]  cpu_wd,
  input  logic           cpu_we,
  input  logic [BEW-1:0] cpu_be,
  output logic [DW-1:0]  cpu_rd,
  output logic           cpu_ack,
  output logic [DW-1:0]  PrAddr,
  output logic [DW-1:0]  PrWD,
  output logic           PrWe,
  output logic [BEW-1:0] PrBE,
  input  logic [DW-1:0]  PrRD,
  output logic [DW-1:0]  sw_data,
  output logic [CW-1:0]  poll_cnt,
  output logic           poll_ovr
);

  localparam int unsigned DIV_W = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(POLL_DIV - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CPU_ACC = 2'd1;
  localparam logic [1:0] S_POLL_RD = 2'd2;
  localparam logic [1:0] S_POLL_WR = 2'd3;

  localparam logic GNT_POLL = 1'b0;
  localparam logic GNT_CPU  = 1'b1;

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             pending_q, pending_d;
  logic             last_grant_q, last_grant_d;
  logic             ovr_q, ovr_d;
  logic [DW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wd_q, wd_d;
  logic             we_q, we_d;
  logic [BEW-1:0]   be_q, be_d;
  logic [DW-1:0]    rd_q, rd_d;
  logic             ack_q, ack_d;
  logic [DW-1:0]    sw_q, sw_d;
  logic [CW-1:0]    poll_cnt_q, poll_cnt_d;

  logic tick, cpu_valid, poll_valid, grant_cpu, grant_poll;

  // A request is ignored during its own ack cycle so it is never served twice.
  assign tick       = poll_en && (div_q == DIV_LAST);
  assign cpu_valid  = cpu_req && !ack_q;
  assign poll_valid = pending_q && poll_en;

  always_comb begin
    state_d      = state_q;
    div_d        = '0;
    pending_d    = pending_q;
    last_grant_d = last_grant_q;
    ovr_d        = ovr_q;
    addr_d       = addr_q;
    wd_d         = wd_q;
    we_d         = we_q;
    be_d         = be_q;
    rd_d         = rd_q;
    ack_d        = 1'b0;
    sw_d         = sw_q;
    poll_cnt_d   = poll_cnt_q;
    grant_cpu    = 1'b0;
    grant_poll   = 1'b0;

    case (state_q)
      S_IDLE: begin
        we_d = 1'b0;
        be_d = '0;
        // Round-robin arbitration is only consulted when both sources compete.
        if (cpu_valid && poll_valid) begin
          grant_cpu    = (last_grant_q == GNT_POLL);
          grant_poll   = (last_grant_q == GNT_CPU);
          last_grant_d = ~last_grant_q;
        end else begin
          grant_cpu  = cpu_valid;
          grant_poll = poll_valid;
        end
        if (grant_cpu) begin
          state_d = S_CPU_ACC;
          addr_d  = cpu_addr;
          wd_d    = cpu_wd;
          we_d    = cpu_we;
          be_d    = cpu_be;
        end else if (grant_poll) begin
          state_d = S_POLL_RD;
          addr_d  = SW_ADDR;
          we_d    = 1'b0;
          be_d    = '1;
        end
      end
      S_CPU_ACC: begin
        rd_d    = PrRD;
        ack_d   = 1'b1;
        we_d    = 1'b0;
        be_d    = '0;
        state_d = S_IDLE;
      end
      S_POLL_RD: begin
        sw_d    = PrRD;
        addr_d  = LED_ADDR;
        wd_d    = PrRD;
        we_d    = 1'b1;
        be_d    = '1;
        state_d = S_POLL_WR;
      end
      S_POLL_WR: begin
        poll_cnt_d = poll_cnt_q + CW'(1);
        we_d       = 1'b0;
        be_d       = '0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (poll_en) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end

    // A tick that coincides with the poll start re-arms pending without overflow.
    if (!poll_en) begin
      pending_d = 1'b0;
    end else if (tick) begin
      pending_d = 1'b1;
      if (pending_q && !grant_poll) begin
        ovr_d = 1'b1;
      end
    end else if (grant_poll) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      pending_q    <= 1'b0;
      last_grant_q <= GNT_POLL;
      ovr_q        <= 1'b0;
      addr_q       <= '0;
      wd_q         <= '0;
      we_q         <= 1'b0;
      be_q         <= '0;
      rd_q         <= '0;
      ack_q        <= 1'b0;
      sw_q         <= '0;
      poll_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      ovr_q        <= ovr_d;
      addr_q       <= addr_d;
      wd_q         <= wd_d;
      we_q         <= we_d;
      be_q         <= be_d;
      rd_q         <= rd_d;
      ack_q        <= ack_d;
      sw_q         <= sw_d;
      poll_cnt_q   <= poll_cnt_d;
    end
  end

  assign cpu_rd   = rd_q;
  assign cpu_ack  = ack_q;
  assign PrAddr   = addr_q;
  assign PrWD     = wd_q;
  assign PrWe     = we_q;
  assign PrBE     = be_q;
  assign sw_data  = sw_q;
  assign poll_cnt = poll_cnt_q;
  assign poll_ovr = ovr_q;

endmodule

// File: tb/tb_io_poll_ctrl.sv
// Directed bench for io_poll_ctrl: one DUT with POLL_DIV=4 for the main scenarios,
// a second with POLL_DIV=2 for the overflow case.
module tb_io_poll_ctrl;

  localparam logic [31:0] SW_ADDR  = 32'h0000_7F2C;
  localparam logic [31:0] LED_ADDR = 32'h0000_7F34;

  logic        clk = 1'b0;
  logic        reset;
  logic        poll_en, cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wd;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_rd, PrAddr, PrWD, PrRD, sw_data;
  logic        cpu_ack, PrWe, poll_ovr;
  logic [3:0]  PrBE;
  logic [15:0] poll_cnt;

  logic        poll_en2, cpu_req2;
  logic [31:0] cpu_rd2, PrAddr2, PrWD2, PrRD2, sw_data2;
  logic        cpu_ack2, PrWe2, poll_ovr2;
  logic [3:0]  PrBE2;
  logic [15:0] poll_cnt2;

  logic [31:0] sw_val, rd_val;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Bridge model: switch register at SW_ADDR, everything else returns rd_val.
  assign PrRD  = (PrAddr  == SW_ADDR) ? sw_val : rd_val;
  assign PrRD2 = (PrAddr2 == SW_ADDR) ? sw_val : rd_val;

  io_poll_ctrl #(.POLL_DIV(4), .SW_ADDR(SW_ADDR), .LED_ADDR(LED_ADDR)) u_dut (
    .clk(clk), .reset(reset), .poll_en(poll_en), .cpu_req(cpu_req),
    .cpu_addr(cpu_addr), .cpu_wd(cpu_wd), .cpu_we(cpu_we), .cpu_be(cpu_be),
    .cpu_rd(cpu_rd), .cpu_ack(cpu_ack), .PrAddr(PrAddr), .PrWD(PrWD),
    .PrWe(PrWe), .PrBE(PrBE), .PrRD(PrRD), .sw_data(sw_data),
    .poll_cnt(poll_cnt), .poll_ovr(poll_ovr)
  );

  io_poll_ctrl #(.POLL_DIV(2), .SW_ADDR(SW_ADDR), .LED_ADDR(LED_ADDR)) u_dut2 (
    .clk(clk), .reset(reset), .poll_en(poll_en2), .cpu_req(cpu_req2),
    .cpu_addr(cpu_addr), .cpu_wd(cpu_wd), .cpu_we(cpu_we), .cpu_be(cpu_be),
    .cpu_rd(cpu_rd2), .cpu_ack(cpu_ack2), .PrAddr(PrAddr2), .PrWD(PrWD2),
    .PrWe(PrWe2), .PrBE(PrBE2), .PrRD(PrRD2), .sw_data(sw_data2),
    .poll_cnt(poll_cnt2), .poll_ovr(poll_ovr2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset released on a falling edge; the next rising edge is edge 1.
  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    checks++;
    if ({PrAddr, PrWD, PrWe, PrBE, cpu_rd, cpu_ack, sw_data, poll_cnt, poll_ovr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%h wd=%h we=%b be=%h rd=%h ack=%b sw=%h cnt=%h ovr=%b, expected all 0",
               PrAddr, PrWD, PrWe, PrBE, cpu_rd, cpu_ack, sw_data, poll_cnt, poll_ovr);
    end
    checks++;
    if (u_dut.state_q !== 2'd0) begin
      errors++; $display("FAIL reset_state: got %0d expected 0", u_dut.state_q);
    end
  endtask

  task automatic test_poll();
    poll_en = 1'b1;
    sw_val  = 32'hA5A5_0F0F;
    apply_reset();
    repeat (4) step();
    checks++;
    if ({PrAddr, PrWe} !== {32'h0, 1'b0}) begin
      errors++; $display("FAIL poll_before_tick: got addr=%h we=%b expected 0/0", PrAddr, PrWe);
    end
    for (int p = 1; p <= 2; p++) begin
      step();
      checks++;
      if ({PrAddr, PrWe, PrBE} !== {SW_ADDR, 1'b0, 4'hF}) begin
        errors++; $display("FAIL poll_rd%0d: got addr=%h we=%b be=%h expected %h/0/f", p, PrAddr, PrWe, PrBE, SW_ADDR);
      end
      step();
      checks++;
      if ({PrAddr, PrWD, PrWe, PrBE} !== {LED_ADDR, 32'hA5A5_0F0F, 1'b1, 4'hF}) begin
        errors++; $display("FAIL poll_wr%0d: got addr=%h wd=%h we=%b be=%h expected %h/a5a50f0f/1/f", p, PrAddr, PrWD, PrWe, PrBE, LED_ADDR);
      end
      checks++;
      if (sw_data !== 32'hA5A5_0F0F) begin
        errors++; $display("FAIL poll_sw_data%0d: got %h expected a5a50f0f", p, sw_data);
      end
      step();
      checks++;
      if ({PrWe, PrBE, poll_cnt} !== {1'b0, 4'h0, 16'(p)}) begin
        errors++; $display("FAIL poll_done%0d: got we=%b be=%h cnt=%0d expected 0/0/%0d", p, PrWe, PrBE, poll_cnt, p);
      end
      if (p == 1) step();
    end
  endtask

  task automatic test_reset_mid_wr();
    int first;
    first = 0;
    repeat (3) step();
    checks++;
    if (PrWe !== 1'b1) begin
      errors++; $display("FAIL mid_wr_setup: got we=%b expected 1", PrWe);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({PrAddr, PrWD, PrWe, PrBE, cpu_ack, sw_data, poll_cnt, poll_ovr} !== '0) begin
      errors++; $display("FAIL mid_wr_reset: got addr=%h wd=%h we=%b be=%h sw=%h cnt=%h expected all 0",
                         PrAddr, PrWD, PrWe, PrBE, sw_data, poll_cnt);
    end
    checks++;
    if (u_dut.state_q !== 2'd0) begin
      errors++; $display("FAIL mid_wr_state: got %0d expected 0", u_dut.state_q);
    end
    @(negedge clk);
    reset = 1'b0;
    // Tick at edge 4 sets pending, the read starts one edge later.
    for (int i = 1; i <= 20; i++) begin
      step();
      if (PrAddr === SW_ADDR) begin
        first = i;
        break;
      end
    end
    checks++;
    if (first != 5) begin
      errors++; $display("FAIL first_poll_after_reset: got edge %0d expected 5", first);
    end
    step();
    step();
    checks++;
    if (poll_cnt !== 16'd1) begin
      errors++; $display("FAIL poll_cnt_after_reset: got %0d expected 1", poll_cnt);
    end
  endtask

  task automatic test_cpu_write();
    poll_en = 1'b0;
    apply_reset();
    step();
    cpu_req = 1'b1; cpu_addr = 32'h0000_7F00; cpu_wd = 32'h1234_5678;
    cpu_we = 1'b1; cpu_be = 4'b0011; rd_val = 32'h0BAD_F00D;
    step();
    checks++;
    if ({PrAddr, PrWD, PrWe, PrBE, cpu_ack} !== {32'h0000_7F00, 32'h1234_5678, 1'b1, 4'b0011, 1'b0}) begin
      errors++; $display("FAIL cpu_wr_bus: got addr=%h wd=%h we=%b be=%h ack=%b expected 00007f00/12345678/1/3/0",
                         PrAddr, PrWD, PrWe, PrBE, cpu_ack);
    end
    step();
    checks++;
    if ({cpu_ack, cpu_rd, PrWe, PrBE} !== {1'b1, 32'h0BAD_F00D, 1'b0, 4'h0}) begin
      errors++; $display("FAIL cpu_wr_ack: got ack=%b rd=%h we=%b be=%h expected 1/0badf00d/0/0", cpu_ack, cpu_rd, PrWe, PrBE);
    end
    step();
    checks++;
    if ({cpu_ack, PrWe, PrBE, u_dut.state_q} !== {1'b0, 1'b0, 4'h0, 2'd0}) begin
      errors++; $display("FAIL cpu_wr_once: got ack=%b we=%b be=%h state=%0d expected 0/0/0/0", cpu_ack, PrWe, PrBE, u_dut.state_q);
    end
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_7F10; cpu_be = 4'hF;
    rd_val = 32'hDEAD_BEEF;
    step();
    checks++;
    if ({PrAddr, PrWe, PrBE} !== {32'h0000_7F10, 1'b0, 4'hF}) begin
      errors++; $display("FAIL cpu_rd_bus: got addr=%h we=%b be=%h expected 00007f10/0/f", PrAddr, PrWe, PrBE);
    end
    step();
    checks++;
    if ({cpu_ack, cpu_rd} !== {1'b1, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL cpu_rd_data: got ack=%b rd=%h expected 1/deadbeef", cpu_ack, cpu_rd);
    end
    cpu_req = 1'b0;
    step();
    checks++;
    if (cpu_ack !== 1'b0) begin
      errors++; $display("FAIL cpu_rd_ack_pulse: got %b expected 0", cpu_ack);
    end
  endtask

  // Contention at edges 4, 9, 12, 17: grants CPU, POLL, CPU, POLL.
  task automatic test_arbitration();
    poll_en = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 4'hF;
    cpu_addr = 32'h0000_1000; rd_val = 32'h0BAD_F00D;
    apply_reset();
    repeat (4) step();
    cpu_req = 1'b1;
    step();
    checks++;
    if (PrAddr !== 32'h0000_1000) begin
      errors++; $display("FAIL arb_grant1_cpu: got addr=%h expected 00001000", PrAddr);
    end
    step();
    checks++;
    if (cpu_ack !== 1'b1) begin
      errors++; $display("FAIL arb_ack1: got %b expected 1", cpu_ack);
    end
    repeat (4) step();
    checks++;
    if (PrAddr !== SW_ADDR) begin
      errors++; $display("FAIL arb_grant2_poll: got addr=%h expected %h", PrAddr, SW_ADDR);
    end
    repeat (3) step();
    checks++;
    if (PrAddr !== 32'h0000_1000) begin
      errors++; $display("FAIL arb_grant3_cpu: got addr=%h expected 00001000", PrAddr);
    end
    repeat (5) step();
    checks++;
    if (PrAddr !== SW_ADDR) begin
      errors++; $display("FAIL arb_grant4_poll: got addr=%h expected %h", PrAddr, SW_ADDR);
    end
    checks++;
    if ({poll_cnt, poll_ovr} !== {16'd3, 1'b0}) begin
      errors++; $display("FAIL arb_counts: got cnt=%0d ovr=%b expected 3/0", poll_cnt, poll_ovr);
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_overflow();
    poll_en = 1'b0; cpu_req = 1'b0;
    poll_en2 = 1'b1; cpu_req2 = 1'b1;
    cpu_addr = 32'h0000_1000; cpu_we = 1'b0; cpu_be = 4'hF;
    rd_val = 32'h0BAD_F00D; sw_val = 32'hA5A5_0F0F;
    apply_reset();
    repeat (5) step();
    checks++;
    if ({poll_cnt2, poll_ovr2} !== {16'd1, 1'b0}) begin
      errors++; $display("FAIL ovr_before: got cnt=%0d ovr=%b expected 1/0", poll_cnt2, poll_ovr2);
    end
    step();
    checks++;
    if (poll_ovr2 !== 1'b1) begin
      errors++; $display("FAIL ovr_set: got %b expected 1", poll_ovr2);
    end
    for (int i = 0; i < 30; i++) begin
      step();
      checks++;
      if (poll_ovr2 !== 1'b1) begin
        errors++; $display("FAIL ovr_sticky: cycle %0d got %b expected 1", i, poll_ovr2);
      end
      if (cpu_ack2 === 1'b1) begin
        checks++;
        if (cpu_rd2 !== 32'h0BAD_F00D) begin
          errors++; $display("FAIL ovr_cpu_rd: got %h expected 0badf00d", cpu_rd2);
        end
      end
      if (PrWe2 === 1'b1) begin
        checks++;
        if ({PrWD2, PrBE2} !== {32'hA5A5_0F0F, 4'hF}) begin
          errors++; $display("FAIL ovr_led_wr: got wd=%h be=%h expected a5a50f0f/f", PrWD2, PrBE2);
        end
      end
    end
    checks++;
    if (poll_cnt2 <= 16'd1) begin
      errors++; $display("FAIL ovr_cnt_advance: got %0d expected > 1", poll_cnt2);
    end
    checks++;
    if (sw_data2 !== 32'hA5A5_0F0F) begin
      errors++; $display("FAIL ovr_sw_data: got %h expected a5a50f0f", sw_data2);
    end
    poll_en2 = 1'b0; cpu_req2 = 1'b0;
  endtask

  // Preloading avoids 65k polls; the count register is held across two idle edges.
  task automatic test_wrap();
    poll_en = 1'b0; cpu_req = 1'b0;
    apply_reset();
    force u_dut.poll_cnt_q = 16'hFFFE;
    step();
    step();
    release u_dut.poll_cnt_q;
    checks++;
    if (poll_cnt !== 16'hFFFE) begin
      errors++; $display("FAIL wrap_preload: got %h expected fffe", poll_cnt);
    end
    poll_en = 1'b1;
    repeat (7) step();
    checks++;
    if (poll_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_ffff: got %h expected ffff", poll_cnt);
    end
    repeat (4) step();
    checks++;
    if (poll_cnt !== 16'h0000) begin
      errors++; $display("FAIL wrap_zero: got %h expected 0000", poll_cnt);
    end
  endtask

  task automatic test_poll_en_drop();
    int busy;
    busy = 0;
    poll_en = 1'b1; cpu_req = 1'b0;
    apply_reset();
    repeat (5) step();
    checks++;
    if (PrAddr !== SW_ADDR) begin
      errors++; $display("FAIL drop_rd: got addr=%h expected %h", PrAddr, SW_ADDR);
    end
    poll_en = 1'b0;
    step();
    checks++;
    if ({PrAddr, PrWe} !== {LED_ADDR, 1'b1}) begin
      errors++; $display("FAIL drop_wr_completes: got addr=%h we=%b expected %h/1", PrAddr, PrWe, LED_ADDR);
    end
    step();
    for (int i = 0; i < 12; i++) begin
      step();
      if (PrBE !== 4'h0 || PrWe !== 1'b0) busy++;
    end
    checks++;
    if (busy != 0) begin
      errors++; $display("FAIL drop_no_more_polls: got %0d busy cycles expected 0", busy);
    end
    checks++;
    if ({poll_cnt, u_dut.div_q, u_dut.pending_q} !== {16'd1, 2'd0, 1'b0}) begin
      errors++; $display("FAIL drop_idle_state: got cnt=%0d div=%0d pend=%b expected 1/0/0",
                         poll_cnt, u_dut.div_q, u_dut.pending_q);
    end
  endtask

  initial begin
    reset = 1'b1; poll_en = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wd = '0; cpu_be = '0;
    poll_en2 = 1'b0; cpu_req2 = 1'b0;
    sw_val = '0; rd_val = '0;
    test_reset();
    test_poll();
    test_reset_mid_wr();
    test_cpu_write();
    test_cpu_read();
    test_arbitration();
    test_overflow();
    test_wrap();
    test_poll_en_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
